// File: rtl/ahb_arbiter_if.sv
// Arbiter-side AHB signal bundle: request/lock/transfer inputs from the muxed
// master path and the registered grant/ownership outputs.
interface ahb_arbiter_if #(
    parameter int NUM_M = 4
);
    logic [NUM_M-1:0] Hbusreq;
    logic [NUM_M-1:0] Hlock;
    logic [1:0]       Htrans;
    logic [2:0]       Hburst;
    logic             Hready;
    logic [NUM_M-1:0] Hgrant;
    logic [1:0]       Hmaster;
    logic [1:0]       Hmaster_data;
    logic             Hmastlock;

    modport slave (
        input  Hbusreq, Hlock, Htrans, Hburst, Hready,
        output Hgrant, Hmaster, Hmaster_data, Hmastlock
    );

    modport master (
        output Hbusreq, Hlock, Htrans, Hburst, Hready,
        input  Hgrant, Hmaster, Hmaster_data, Hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Four-master round-robin AHB arbiter; fixed-length bursts and locked
// sequences hold the grant, address and data-phase owners tracked separately.
module ahb_arbiter #(
    parameter int NUM_M          = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic          Hclk,
    input  logic          Hreset,
    ahb_arbiter_if.slave  bus
);
    localparam logic [1:0]       DEF     = 2'(DEFAULT_MASTER);
    localparam logic [NUM_M-1:0] DEF_GNT = NUM_M'(1) << DEFAULT_MASTER;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic [NUM_M-1:0] grant_q, grant_d;
    logic [1:0]       master_q, master_d;
    logic [1:0]       mdata_q, mdata_d;
    logic             mlock_q, mlock_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [1:0] gnt_idx;
    logic [1:0] win;
    logic [1:0] cand;
    logic       found;
    logic       hold;
    logic [3:0] beats_m1;

    always_comb begin
        gnt_idx = DEF;
        for (int i = 0; i < NUM_M; i++)
            if (grant_q[i]) gnt_idx = 2'(i);
    end

    always_comb begin
        case (bus.Hburst)
            3'b010, 3'b011: beats_m1 = 4'd3;
            3'b100, 3'b101: beats_m1 = 4'd7;
            3'b110, 3'b111: beats_m1 = 4'd15;
            default:        beats_m1 = 4'd0;
        endcase
    end

    // Counter advances only on completed beats; IDLE clears it so an early
    // terminated burst cannot leave the grant stuck.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.Hready) begin
            case (bus.Htrans)
                T_NONSEQ: cnt_d = beats_m1;
                T_SEQ:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                T_IDLE:   cnt_d = 4'd0;
                default:  cnt_d = cnt_q;
            endcase
        end
    end

    assign hold = ((cnt_q != 4'd0) && (bus.Htrans != T_IDLE)) ||
                  (bus.Hlock[master_q] && bus.Hbusreq[master_q]);

    // Scan starts just past the last winner and ends on it, so the previous
    // owner is only re-granted when nobody else asks.
    always_comb begin
        found = 1'b0;
        win   = DEF;
        cand  = last_q;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = last_q + 2'(k);
            if (!found && bus.Hbusreq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        if (!hold) begin
            if (found) begin
                grant_d = NUM_M'(1) << win;
                last_d  = win;
            end else begin
                grant_d = DEF_GNT;
            end
        end
    end

    always_comb begin
        master_d = master_q;
        mdata_d  = mdata_q;
        mlock_d  = mlock_q;
        if (bus.Hready) begin
            master_d = gnt_idx;
            mdata_d  = master_q;
            mlock_d  = bus.Hlock[gnt_idx];
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            grant_q  <= DEF_GNT;
            master_q <= DEF;
            mdata_q  <= DEF;
            mlock_q  <= 1'b0;
            cnt_q    <= 4'd0;
            last_q   <= DEF;
        end else begin
            grant_q  <= grant_d;
            master_q <= master_d;
            mdata_q  <= mdata_d;
            mlock_q  <= mlock_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign bus.Hgrant       = grant_q;
    assign bus.Hmaster      = master_q;
    assign bus.Hmaster_data = mdata_q;
    assign bus.Hmastlock    = mlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter: a cycle model pushes expected outputs to a
// scoreboard queue, plus directed constant checks per scenario.
module tb_ahb_arbiter;
    logic Hclk;
    logic Hreset;

    ahb_arbiter_if #(.NUM_M(4)) bus ();

    ahb_arbiter #(.NUM_M(4), .DEFAULT_MASTER(0)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] d;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] m_grant;
    logic [1:0] m_master, m_data, m_last;
    logic       m_lock;
    logic [3:0] m_cnt;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

    // One bus cycle: drive, predict, push, clock, pop and compare.
    task automatic step(input logic [3:0] req, input logic [3:0] lk,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic rst);
        exp_t e, got;
        logic hold_m, found;
        int   gi, w, c;
        bus.Hbusreq = req;
        bus.Hlock   = lk;
        bus.Htrans  = tr;
        bus.Hburst  = bu;
        bus.Hready  = rdy;
        Hreset      = rst;
        if (rst) begin
            m_grant = 4'b0001; m_master = 0; m_data = 0; m_lock = 0;
            m_cnt = 0; m_last = 0;
        end else begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (m_grant[i]) gi = i;
            hold_m = (m_cnt != 0 && tr != IDLE) || (lk[m_master] && req[m_master]);
            found = 0; w = 0;
            for (int k = 1; k <= 4; k++) begin
                c = (int'(m_last) + k) % 4;
                if (!found && req[c]) begin found = 1; w = c; end
            end
            if (rdy) begin
                m_lock = lk[gi];
                m_data = m_master;
                m_master = 2'(gi);
                if (tr == NONSEQ)
                    m_cnt = (bu[2:1] == 2'b01) ? 4'd3 : (bu[2:1] == 2'b10) ? 4'd7 :
                            (bu[2:1] == 2'b11) ? 4'd15 : 4'd0;
                else if (tr == SEQ && m_cnt != 0) m_cnt = m_cnt - 1;
                else if (tr == IDLE) m_cnt = 0;
            end
            if (!hold_m) begin
                m_grant = found ? (4'b0001 << w) : 4'b0001;
                if (found) m_last = 2'(w);
            end
        end
        e.g = m_grant; e.m = m_master; e.d = m_data; e.l = m_lock;
        sb.push_back(e);
        @(posedge Hclk);
        #1;
        e = sb.pop_front();
        got = '{bus.Hgrant, bus.Hmaster, bus.Hmaster_data, bus.Hmastlock};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL sb_cycle t=%0t: got g=%b m=%0d d=%0d l=%b, want g=%b m=%0d d=%0d l=%b",
                     $time, got.g, got.m, got.d, got.l, e.g, e.m, e.d, e.l);
        end
    endtask

    task automatic test_reset();
        step(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        step(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        n_cmp++;
        if (bus.Hgrant !== 4'b0001 || bus.Hmaster !== 2'd0 ||
            bus.Hmaster_data !== 2'd0 || bus.Hmastlock !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: g=%b m=%0d d=%0d l=%b want 0001/0/0/0",
                     bus.Hgrant, bus.Hmaster, bus.Hmaster_data, bus.Hmastlock);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg[6];
        logic [1:0] em[6];
        logic [1:0] ed[6];
        eg = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        em = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ed = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        step(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
            n_cmp++;
            if (bus.Hgrant !== eg[i] || bus.Hmaster !== em[i] || bus.Hmaster_data !== ed[i]) begin
                n_err++;
                $display("FAIL round_robin[%0d]: g=%b m=%0d d=%0d want g=%b m=%0d d=%0d",
                         i, bus.Hgrant, bus.Hmaster, bus.Hmaster_data, eg[i], em[i], ed[i]);
            end
        end
    endtask

    // Master 2 takes the bus and starts INCR4; wait_cycles stalls at beat 2.
    task automatic test_burst(input int wait_cycles);
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
        for (int i = 0; i < wait_cycles; i++) begin
            step(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, 1'b0);
            n_cmp++;
            if (bus.Hgrant !== 4'b0100 || bus.Hmaster !== 2'd2) begin
                n_err++;
                $display("FAIL burst_wait[%0d]: g=%b m=%0d want 0100/2", i, bus.Hgrant, bus.Hmaster);
            end
        end
        step(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
        step(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0100) begin
            n_err++;
            $display("FAIL burst_tail_hold: g=%b want 0100", bus.Hgrant);
        end
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0010 || bus.Hmaster !== 2'd2) begin
            n_err++;
            $display("FAIL burst_regrant: g=%b m=%0d want 0010/2", bus.Hgrant, bus.Hmaster);
        end
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hmaster !== 2'd1) begin
            n_err++;
            $display("FAIL burst_handover: m=%0d want 1", bus.Hmaster);
        end
    endtask

    task automatic test_locked();
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        step(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 4'b1000, NONSEQ, SINGLE, 1'b1, 1'b0);
            n_cmp++;
            if (bus.Hgrant !== 4'b1000 || bus.Hmaster !== 2'd3 || bus.Hmastlock !== 1'b1) begin
                n_err++;
                $display("FAIL locked_hold[%0d]: g=%b m=%0d l=%b want 1000/3/1",
                         i, bus.Hgrant, bus.Hmaster, bus.Hmastlock);
            end
        end
        step(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0001) begin
            n_err++;
            $display("FAIL locked_release: g=%b want 0001", bus.Hgrant);
        end
    endtask

    task automatic test_no_requests();
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0001) begin
            n_err++;
            $display("FAIL idle_default: g=%b want 0001", bus.Hgrant);
        end
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0010) begin
            n_err++;
            $display("FAIL idle_then_m1: g=%b want 0010", bus.Hgrant);
        end
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        // last is still 1, so master 0 wins over master 1
        step(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0001) begin
            n_err++;
            $display("FAIL idle_keeps_last: g=%b want 0001", bus.Hgrant);
        end
    endtask

    task automatic test_reset_mid_burst();
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
        step(4'b1111, 4'b0000, SEQ, INCR4, 1'b1, 1'b1);
        n_cmp++;
        if (bus.Hgrant !== 4'b0001 || bus.Hmaster !== 2'd0 || bus.Hmaster_data !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid: g=%b m=%0d d=%0d want 0001/0/0",
                     bus.Hgrant, bus.Hmaster, bus.Hmaster_data);
        end
        // counter must be cleared, so a SEQ does not hold the grant
        step(4'b1111, 4'b0000, SEQ, INCR4, 1'b1, 1'b0);
        n_cmp++;
        if (bus.Hgrant !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_mid_cnt: g=%b want 0010", bus.Hgrant);
        end
    endtask

    initial begin
        Hreset = 1'b1;
        bus.Hbusreq = '0; bus.Hlock = '0; bus.Htrans = IDLE;
        bus.Hburst = SINGLE; bus.Hready = 1'b1;
        m_grant = 4'b0001; m_master = 0; m_data = 0; m_lock = 0; m_cnt = 0; m_last = 0;
        @(posedge Hclk);
        #1;
        test_reset();
        test_round_robin();
        test_burst(0);
        test_burst(3);
        test_locked();
        test_no_requests();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Four-master AHB bus arbiter. It decides which master owns the shared address/control/write-data path and drives the `Hmaster` select for the master-to-slave multiplexer. Arbitration is round-robin. Fixed-length bursts and locked sequences are never split. Address-phase ownership (`Hmaster`) and data-phase ownership (`Hmaster_data`) are tracked separately so write data and responses follow the correct master.

## Interface
- `NUM_M`, 4: number of masters; fixed at 4 in this revision, so `Hmaster` is 2 bits.
- `DEFAULT_MASTER`, 0: master granted when nothing is requested, and after reset.

Ports:
- `Hclk`  in  1: bus clock; all state updates on the rising edge.
- `Hreset`  in  1: synchronous, active-high reset.
- `Hbusreq`  in  4: per-master bus request.
- `Hlock`  in  4: per-master locked-transfer request.
- `Htrans`  in  2: muxed transfer type from the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `Hburst`  in  3: muxed burst type from the current owner.
- `Hready`  in  1: transfer-complete from the slave side.
- `Hgrant`  out  4: one-hot grant, registered.
- `Hmaster`  out  2: address-phase owner index; drives the mux select.
- `Hmaster_data`  out  2: data-phase owner index.
- `Hmastlock`  out  1: current address phase belongs to a locked sequence.

## Operation
- **Reset.** Hold `Hreset` high for one or more edges. Afterwards:
  - `Hgrant` is one-hot at `DEFAULT_MASTER`.
  - `Hmaster` and `Hmaster_data` equal `DEFAULT_MASTER`.
  - `Hmastlock` is 0.
  - Beat counter is 0.
  - Round-robin pointer `last` equals `DEFAULT_MASTER`.
- **Beat counter (4-bit).**
  - On `Hready` with `Htrans`=NONSEQ, load beats−1: INCR4/WRAP4 load 3, INCR8/WRAP8 load 7, INCR16/WRAP16 load 15. SINGLE and INCR load 0.
  - On `Hready` with `Htrans`=SEQ and counter>0, decrement.
  - On `Hready` with `Htrans`=IDLE, clear to 0. This covers early termination.
  - BUSY leaves the counter unchanged.
- **Hold condition.** `hold` = (counter>0 and `Htrans`≠IDLE) or (`Hlock`[`Hmaster`] and `Hbusreq`[`Hmaster`]).
- **Re-arbitration.** Performed on every edge where `hold`=0:
  - The winner is the first requesting master scanning `last`+1, `last`+2, … (mod 4), ending at `last`. `Hgrant` takes this winner, even when it equals the current owner.
  - If no master requests, `Hgrant` goes to `DEFAULT_MASTER`.
  - `last` updates to the winner only when a real request was granted.
- **While `hold`=1.** `Hgrant` and `last` are unchanged.
- **Ownership handover.**
  - On an edge with `Hready`=1: `Hmaster` ← index of the `Hgrant` value present before that edge; `Hmaster_data` ← old `Hmaster`; `Hmastlock` ← `Hlock`[granted index].
  - With `Hready`=0, all three hold their values.
- **Simultaneous events.** If a new NONSEQ on the current owner coincides with another master's request and `hold`=0, arbitration proceeds normally. The new burst's counter load is still taken from the current owner's NONSEQ.
- **Reset during a transfer.** All state returns to the reset values on the same edge; in-flight bursts are abandoned.

## Timing
- Request to grant: a request seen at edge N with `hold`=0 gives `Hgrant` at N+1.
- Grant to ownership: `Hmaster` changes at the first edge ≥ N+2 with `Hready`=1.
- Ownership to data phase: `Hmaster_data` follows `Hmaster` one `Hready` edge later.
- Burst tail: during a 4-beat burst with `Hready` tied high, `Hgrant` can change no earlier than the edge that consumes the last SEQ beat, which is when the counter reaches 0.
- Wait states: `Hready`=0 stretches everything. The counter, `Hmaster`, and `Hmaster_data` are frozen. `Hgrant` may still change if `hold`=0.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- **Reset.** Assert `Hreset` for 2 cycles with `Hbusreq`=1111 → `Hgrant`=0001, `Hmaster`=0, `Hmaster_data`=0, `Hmastlock`=0.
- **Round-robin.** Hold `Hbusreq`=1111 and `Hready`=1; owners issue SINGLE NONSEQ transfers → `Hmaster` sequence 1,2,3,0,1, one change per cycle after the first grant. `Hmaster_data` trails `Hmaster` by one cycle.
- **INCR4 burst.** Master 2 owns the bus and issues NONSEQ then 3×SEQ with INCR4; master 1 requests during the burst → `Hgrant` stays 0100 until the third SEQ edge, then becomes 0010. `Hmaster`=1 on the following edge.
- **Wait states.** Same burst with `Hready`=0 for 3 cycles at beat 2 → counter holds at 2 and `Hmaster` stays 2. The handover occurs 3 cycles later than in the `Hready`=1 case.
- **Locked sequence.** Master 3 has `Hlock`=1, `Hbusreq`=1 across three SINGLE transfers; masters 0–2 request → `Hgrant`=1000 throughout and `Hmastlock`=1. When `Hlock` drops, the next grant is master 0.
- **No requests.** `Hbusreq`=0000 → `Hgrant`=0001 (`DEFAULT_MASTER`). `last` is unchanged, so a later request from master 1 alone is granted within 1 cycle.
